// File: rtl/dadda_multiplier_unit_if.sv
// Operand/product bus of the Dadda multiplier.
// master drives operands, slave returns the registered product.
interface dadda_multiplier_unit_if #(
   parameter int n = 16
);
   logic [n-1:0]   a;
   logic [n-1:0]   b;
   logic [2*n-1:0] prod;

   modport master (
      output a,
      output b,
      input  prod
   );

   modport slave (
      input  a,
      input  b,
      output prod
   );
endinterface

// File: rtl/dadda_multiplier_unit.sv
// Unsigned n x n Dadda-tree multiplier with a registered 2n-bit product.
// A new operand pair is accepted every cycle; the product lands one edge later.
module dadda_multiplier_unit #(
   parameter int n = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   dadda_multiplier_unit_if.slave bus
);

   localparam int W = 2 * n;

   // Dadda sequence: 2, 3, 4, 6, 9, 13, 19, ...
   function automatic int dseq(input int k);
      int d;
      d = 2;
      for (int i = 1; i < k; i++) begin
         d = (d * 3) / 2;
      end
      return d;
   endfunction

   function automatic int nstages();
      int s;
      s = 0;
      for (int k = 1; k < 32; k++) begin
         if (dseq(k) < n) begin
            s = k;
         end
      end
      return s;
   endfunction

   localparam int S = nstages();

   logic [n-1:0] cur [W];
   logic [n-1:0] nxt [W];
   int           h   [W];
   int           nh  [W];
   int           tgt;
   int           exc;
   int           nfa;
   int           nha;
   int           k;
   logic         cy;
   logic         sm;
   logic [W-1:0] row0;
   logic [W-1:0] row1;
   logic [W-1:0] sum;

   // Heights are pure functions of the loop indices, so the loops
   // unroll into a fixed tree of full and half adders.
   always_comb begin
      tgt  = 0;
      exc  = 0;
      nfa  = 0;
      nha  = 0;
      k    = 0;
      cy   = 1'b0;
      sm   = 1'b0;
      row0 = '0;
      row1 = '0;
      for (int c = 0; c < W; c++) begin
         cur[c] = '0;
         nxt[c] = '0;
         h[c]   = 0;
         nh[c]  = 0;
      end

      for (int i = 0; i < n; i++) begin
         for (int j = 0; j < n; j++) begin
            cur[i+j][h[i+j]] = bus.a[j] & bus.b[i];
            h[i+j] = h[i+j] + 1;
         end
      end

      for (int s = 0; s < S; s++) begin
         tgt = dseq(S - s);
         for (int c = 0; c < W; c++) begin
            nxt[c] = '0;
            nh[c]  = 0;
         end
         for (int c = 0; c < W; c++) begin
            // nh[c] already holds the carries pushed in from column c-1
            exc = h[c] + nh[c] - tgt;
            nfa = (exc > 0) ? exc / 2 : 0;
            nha = (exc > 0) ? exc % 2 : 0;
            k   = 0;
            for (int f = 0; f < n; f++) begin
               if (f < nfa) begin
                  {cy, sm} = {1'b0, cur[c][k]}
                           + {1'b0, cur[c][k+1]}
                           + {1'b0, cur[c][k+2]};
                  nxt[c][nh[c]] = sm;
                  nh[c] = nh[c] + 1;
                  if (c + 1 < W) begin
                     nxt[c+1][nh[c+1]] = cy;
                     nh[c+1] = nh[c+1] + 1;
                  end
                  k = k + 3;
               end
            end
            if (nha > 0) begin
               {cy, sm} = {1'b0, cur[c][k]} + {1'b0, cur[c][k+1]};
               nxt[c][nh[c]] = sm;
               nh[c] = nh[c] + 1;
               if (c + 1 < W) begin
                  nxt[c+1][nh[c+1]] = cy;
                  nh[c+1] = nh[c+1] + 1;
               end
               k = k + 2;
            end
            for (int p = 0; p < n; p++) begin
               if (p >= k && p < h[c]) begin
                  nxt[c][nh[c]] = cur[c][p];
                  nh[c] = nh[c] + 1;
               end
            end
         end
         for (int c = 0; c < W; c++) begin
            cur[c] = nxt[c];
            h[c]   = nh[c];
         end
      end

      for (int c = 0; c < W; c++) begin
         row0[c] = cur[c][0];
         row1[c] = cur[c][1];
      end
   end

   // Final carry-propagate add; the carry out of the top bit is always zero.
   assign sum = row0 + row1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.prod <= '0;
      end else begin
         bus.prod <= sum;
      end
   end

endmodule

// File: tb/tb_dadda_multiplier_unit.sv
// Scoreboard bench for dadda_multiplier_unit.
// Expected products are queued at drive time and popped one edge later.
module tb_dadda_multiplier_unit;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   logic [31:0] exp_q [$];

   dadda_multiplier_unit_if #(.n(16)) bus ();

   dadda_multiplier_unit #(.n(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive(input logic [15:0] x, input logic [15:0] y);
      @(negedge clk);
      bus.a = x;
      bus.b = y;
      exp_q.push_back({16'h0, x} * {16'h0, y});
   endtask

   task automatic pop_check(input string name);
      logic [31:0] want;
      logic [31:0] got;
      @(posedge clk);
      #1;
      got = bus.prod;
      total++;
      if (exp_q.size() == 0) begin
         bad++;
         $display("FAIL %s: scoreboard empty, prod=%h", name, got);
      end else begin
         want = exp_q.pop_front();
         if (got !== want) begin
            bad++;
            $display("FAIL %s: a=%h b=%h prod=%h want=%h",
                     name, bus.a, bus.b, got, want);
         end
      end
   endtask

   task automatic step(input logic [15:0] x, input logic [15:0] y,
                       input string name);
      drive(x, y);
      pop_check(name);
   endtask

   task automatic test_reset();
      logic [31:0] got;
      rst = 1'b1;
      bus.a = 16'h1234;
      bus.b = 16'h5678;
      #1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         got = bus.prod;
         total++;
         if (got !== 32'h0) begin
            bad++;
            $display("FAIL reset_hold: prod=%h want=00000000", got);
         end
      end
      @(negedge clk);
      rst = 1'b0;
      exp_q.push_back(32'h0626_0060);
      pop_check("reset_release");
   endtask

   task automatic test_small();
      for (int i = 0; i < 16; i++) begin
         for (int j = 0; j < 16; j++) begin
            step(i[15:0], j[15:0], "small");
         end
      end
   endtask

   task automatic test_corners();
      step(16'hFFFF, 16'hFFFF, "corner_max");
      step(16'hFFFF, 16'h0001, "corner_ffff_1");
      step(16'h8000, 16'h8000, "corner_msb");
      step(16'h0000, 16'hFFFF, "corner_zero");
   endtask

   task automatic test_back_to_back();
      logic [31:0] want [3];
      logic [31:0] got;
      want[0] = 32'd15;
      want[1] = 32'h0001_FFFE;
      want[2] = 32'h0001_0000;
      @(negedge clk);
      bus.a = 16'd3;
      bus.b = 16'd5;
      @(negedge clk);
      bus.a = 16'hFFFF;
      bus.b = 16'd2;
      got = bus.prod;
      total++;
      if (got !== want[0]) begin
         bad++;
         $display("FAIL b2b_0: prod=%h want=%h", got, want[0]);
      end
      @(negedge clk);
      bus.a = 16'h1000;
      bus.b = 16'h0010;
      got = bus.prod;
      total++;
      if (got !== want[1]) begin
         bad++;
         $display("FAIL b2b_1: prod=%h want=%h", got, want[1]);
      end
      @(negedge clk);
      got = bus.prod;
      total++;
      if (got !== want[2]) begin
         bad++;
         $display("FAIL b2b_2: prod=%h want=%h", got, want[2]);
      end
   endtask

   task automatic test_mid_reset();
      logic [31:0] got;
      step(16'h00AB, 16'h00CD, "stream_0");
      step(16'h1357, 16'h2468, "stream_1");
      drive(16'h0F0F, 16'h3003);
      #2;
      rst = 1'b1;
      #1;
      got = bus.prod;
      total++;
      if (got !== 32'h0) begin
         bad++;
         $display("FAIL mid_reset_async: prod=%h want=00000000", got);
      end
      #1;
      rst = 1'b0;
      #0.5;
      got = bus.prod;
      total++;
      if (got !== 32'h0) begin
         bad++;
         $display("FAIL mid_reset_hold: prod=%h want=00000000", got);
      end
      pop_check("mid_reset_reload");
   endtask

   task automatic test_random();
      for (int i = 0; i < 10000; i++) begin
         step(16'($urandom), 16'($urandom), "random");
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      bus.a = '0;
      bus.b = '0;
      test_reset();
      test_small();
      test_corners();
      test_back_to_back();
      test_mid_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
